// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   MEM stage of a 5-stage MIPS32 pipeline. Performs the data-memory access
//   through a req/ack handshake, stalls upstream while memory is busy, resolves
//   the branch and drives the MEM/WB register.
//
//   Optional feature macro: MEM_TIMEOUT_EN
//     When defined, a WAIT_ACK that lasts TIMEOUT_CYCLES cycles without an ack
//     is aborted and reported through Mem_Fault. When undefined, WAIT_ACK waits
//     forever and Mem_Fault is tied to 0.
//
//   Parameters
//     TIMEOUT_CYCLES   WAIT_ACK cycles without ack before abort (>= 2)
//     STALL_CNT_WIDTH  width of the saturating stall-cycle counter
//
//   Ports
//     Clk, Reset_n                 clock (rising edge), async active-low reset
//     *_MEM                        control, data and flags from EX/MEM
//     Dmem_Req/We/Addr/Wdata       data-memory request (outputs)
//     Dmem_Rdata, Dmem_Ack         data-memory response (inputs)
//     Stall_MEM                    freeze PC, IF/ID, ID/EX, EX/MEM
//     PCSrc_MEM, Branch_Target     branch resolution
//     *_WB                         registered MEM/WB outputs
//     Align_Fault, Mem_Fault       registered one-cycle fault pulses
//     Stall_Count                  saturating count of Stall_MEM cycles
// -----------------------------------------------------------------------------
module mem_access_stage #(
   parameter int TIMEOUT_CYCLES  = 16,
   parameter int STALL_CNT_WIDTH = 16
) (
   input  logic                       Clk,
   input  logic                       Reset_n,
   input  logic                       RegWrite_MEM,
   input  logic                       MemtoReg_MEM,
   input  logic                       Branch_MEM,
   input  logic                       MemRead_MEM,
   input  logic                       MemWrite_MEM,
   input  logic                       Zero_MEM,
   input  logic [31:0]                Branch_Dest_MEM,
   input  logic [31:0]                ALU_Result_MEM,
   input  logic [31:0]                Write_Data_MEM,
   input  logic [31:0]                Instruction_MEM,
   input  logic [4:0]                 Write_Register_MEM,
   output logic                       Dmem_Req,
   output logic                       Dmem_We,
   output logic [31:0]                Dmem_Addr,
   output logic [31:0]                Dmem_Wdata,
   input  logic [31:0]                Dmem_Rdata,
   input  logic                       Dmem_Ack,
   output logic                       Stall_MEM,
   output logic                       PCSrc_MEM,
   output logic [31:0]                Branch_Target,
   output logic                       RegWrite_WB,
   output logic                       MemtoReg_WB,
   output logic [31:0]                Read_Data_WB,
   output logic [31:0]                ALU_Result_WB,
   output logic [31:0]                Instruction_WB,
   output logic [4:0]                 Write_Register_WB,
   output logic                       Align_Fault,
   output logic                       Mem_Fault,
   output logic [STALL_CNT_WIDTH-1:0] Stall_Count
);

   typedef enum logic {IDLE, WAIT_ACK} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;

   logic        access, aligned;
   logic        req_int, we_int;
   logic [31:0] addr_int, wdata_int;
   logic        timeout_hit;   // WAIT_ACK has lasted its final allowed cycle
   logic        timeout_fire;  // abort the access at the coming edge
   logic        suppress_req;  // hold off re-issuing the aborted access

   logic                       regwrite_wb_q, regwrite_wb_d;
   logic                       memtoreg_wb_q, memtoreg_wb_d;
   logic [31:0]                read_data_wb_q, read_data_wb_d;
   logic [31:0]                alu_result_wb_q, alu_result_wb_d;
   logic [31:0]                instruction_wb_q, instruction_wb_d;
   logic [4:0]                 write_register_wb_q, write_register_wb_d;
   logic                       align_fault_q, align_fault_d;
   logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

   assign access  = MemRead_MEM | MemWrite_MEM;
   assign aligned = (ALU_Result_MEM[1:0] == 2'b00);

   // ---------------------------------------------------------------------------
   // Optional access timeout
   // ---------------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            mem_fault_q, mem_fault_d;

   // to_cnt_q holds the number of WAIT_ACK cycles already spent on this access.
   assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
   // The EX/MEM register still holds the aborted access in the cycle after the
   // abort; blocking the request there lets the stall release and the pipe move.
   assign suppress_req = mem_fault_q;

   always_comb begin
      to_cnt_d    = '0;
      mem_fault_d = timeout_fire;
      if (state_q == WAIT_ACK && state_d == WAIT_ACK)
         to_cnt_d = to_cnt_q + 1'b1;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         to_cnt_q    <= '0;
         mem_fault_q <= 1'b0;
      end else begin
         to_cnt_q    <= to_cnt_d;
         mem_fault_q <= mem_fault_d;
      end
   end

   assign Mem_Fault = mem_fault_q;
`else
   assign timeout_hit  = 1'b0;
   assign suppress_req = 1'b0;
   assign Mem_Fault    = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Handshake FSM: next state and request outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      req_int      = 1'b0;
      we_int       = MemWrite_MEM;   // store wins when both read and write set
      addr_int     = ALU_Result_MEM;
      wdata_int    = Write_Data_MEM;
      timeout_fire = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (access && aligned && !suppress_req) begin
               req_int = 1'b1;
               if (!Dmem_Ack) begin
                  state_d = WAIT_ACK;
                  addr_d  = ALU_Result_MEM;
                  wdata_d = Write_Data_MEM;
                  we_d    = MemWrite_MEM;
               end
            end
         end
         WAIT_ACK: begin
            req_int   = 1'b1;
            we_int    = we_q;
            addr_int  = addr_q;
            wdata_int = wdata_q;
            // An ack arriving in the timeout cycle completes normally.
            if (Dmem_Ack) begin
               state_d = IDLE;
            end else if (timeout_hit) begin
               state_d      = IDLE;
               timeout_fire = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign Dmem_Req      = req_int & Reset_n;
   assign Dmem_We       = we_int;
   assign Dmem_Addr     = addr_int;
   assign Dmem_Wdata    = wdata_int;
   assign Stall_MEM     = Dmem_Req & ~Dmem_Ack;
   assign PCSrc_MEM     = Branch_MEM & Zero_MEM & ~Stall_MEM;
   assign Branch_Target = Branch_Dest_MEM;

   // ---------------------------------------------------------------------------
   // MEM/WB register next state
   // ---------------------------------------------------------------------------
   always_comb begin
      regwrite_wb_d       = regwrite_wb_q;
      memtoreg_wb_d       = memtoreg_wb_q;
      read_data_wb_d      = read_data_wb_q;
      alu_result_wb_d     = alu_result_wb_q;
      instruction_wb_d    = instruction_wb_q;
      write_register_wb_d = write_register_wb_q;
      align_fault_d       = (state_q == IDLE) && access && !aligned;
      stall_cnt_d         = stall_cnt_q;

      if (Stall_MEM && !(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + 1'b1;

      if (Dmem_Req && Dmem_Ack) begin
         regwrite_wb_d       = RegWrite_MEM;
         memtoreg_wb_d       = MemtoReg_MEM;
         read_data_wb_d      = Dmem_We ? 32'h0 : Dmem_Rdata;
         alu_result_wb_d     = ALU_Result_MEM;
         instruction_wb_d    = Instruction_MEM;
         write_register_wb_d = Write_Register_MEM;
      end else if (!Stall_MEM && !access) begin
         regwrite_wb_d       = RegWrite_MEM;
         memtoreg_wb_d       = MemtoReg_MEM;
         read_data_wb_d      = 32'h0;
         alu_result_wb_d     = ALU_Result_MEM;
         instruction_wb_d    = Instruction_MEM;
         write_register_wb_d = Write_Register_MEM;
      end else begin
         // Stalled, misaligned or aborted access: send a bubble down the pipe.
         regwrite_wb_d    = 1'b0;
         memtoreg_wb_d    = 1'b0;
         instruction_wb_d = 32'h0;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q             <= IDLE;
         addr_q              <= '0;
         wdata_q             <= '0;
         we_q                <= 1'b0;
         regwrite_wb_q       <= 1'b0;
         memtoreg_wb_q       <= 1'b0;
         read_data_wb_q      <= '0;
         alu_result_wb_q     <= '0;
         instruction_wb_q    <= '0;
         write_register_wb_q <= '0;
         align_fault_q       <= 1'b0;
         stall_cnt_q         <= '0;
      end else begin
         state_q             <= state_d;
         addr_q              <= addr_d;
         wdata_q             <= wdata_d;
         we_q                <= we_d;
         regwrite_wb_q       <= regwrite_wb_d;
         memtoreg_wb_q       <= memtoreg_wb_d;
         read_data_wb_q      <= read_data_wb_d;
         alu_result_wb_q     <= alu_result_wb_d;
         instruction_wb_q    <= instruction_wb_d;
         write_register_wb_q <= write_register_wb_d;
         align_fault_q       <= align_fault_d;
         stall_cnt_q         <= stall_cnt_d;
      end
   end

   assign RegWrite_WB       = regwrite_wb_q;
   assign MemtoReg_WB       = memtoreg_wb_q;
   assign Read_Data_WB      = read_data_wb_q;
   assign ALU_Result_WB     = alu_result_wb_q;
   assign Instruction_WB    = instruction_wb_q;
   assign Write_Register_WB = write_register_wb_q;
   assign Align_Fault       = align_fault_q;
   assign Stall_Count       = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//   Directed and randomized instruction sequences for mem_access_stage. The
//   reference model works per instruction: an aligned access with ack latency L
//   requests for L+1 cycles, stalls for L of them, bubbles WB L times and then
//   retires; anything else retires or faults in one cycle. With MEM_TIMEOUT_EN
//   the DUT is built with TIMEOUT_CYCLES=4 and the abort path is exercised.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

   localparam int TO_CYC = 4;
   localparam int SCW    = 16;

   logic        Clk, Reset_n;
   logic        RegWrite_MEM, MemtoReg_MEM, Branch_MEM, MemRead_MEM, MemWrite_MEM, Zero_MEM;
   logic [31:0] Branch_Dest_MEM, ALU_Result_MEM, Write_Data_MEM, Instruction_MEM;
   logic [4:0]  Write_Register_MEM;
   logic        Dmem_Req, Dmem_We, Dmem_Ack;
   logic [31:0] Dmem_Addr, Dmem_Wdata, Dmem_Rdata;
   logic        Stall_MEM, PCSrc_MEM;
   logic [31:0] Branch_Target;
   logic        RegWrite_WB, MemtoReg_WB;
   logic [31:0] Read_Data_WB, ALU_Result_WB, Instruction_WB;
   logic [4:0]  Write_Register_WB;
   logic        Align_Fault, Mem_Fault;
   logic [SCW-1:0] Stall_Count;

   int checks   = 0;
   int failures = 0;

   // reference model of the MEM/WB register and counters
   logic        m_rw, m_mtr;
   logic [31:0] m_rd, m_alu, m_ins;
   logic [4:0]  m_wreg;
   int          m_scnt;

   mem_access_stage #(.TIMEOUT_CYCLES(TO_CYC), .STALL_CNT_WIDTH(SCW)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM), .Branch_MEM(Branch_MEM),
      .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .Zero_MEM(Zero_MEM),
      .Branch_Dest_MEM(Branch_Dest_MEM), .ALU_Result_MEM(ALU_Result_MEM),
      .Write_Data_MEM(Write_Data_MEM), .Instruction_MEM(Instruction_MEM),
      .Write_Register_MEM(Write_Register_MEM),
      .Dmem_Req(Dmem_Req), .Dmem_We(Dmem_We), .Dmem_Addr(Dmem_Addr), .Dmem_Wdata(Dmem_Wdata),
      .Dmem_Rdata(Dmem_Rdata), .Dmem_Ack(Dmem_Ack),
      .Stall_MEM(Stall_MEM), .PCSrc_MEM(PCSrc_MEM), .Branch_Target(Branch_Target),
      .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB), .Read_Data_WB(Read_Data_WB),
      .ALU_Result_WB(ALU_Result_WB), .Instruction_WB(Instruction_WB),
      .Write_Register_WB(Write_Register_WB),
      .Align_Fault(Align_Fault), .Mem_Fault(Mem_Fault), .Stall_Count(Stall_Count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired before the sequence completed");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_wb(input string tag, input logic exp_align, input logic exp_mf);
      chk({tag, ".RegWrite_WB"}, {31'h0, RegWrite_WB}, {31'h0, m_rw});
      chk({tag, ".MemtoReg_WB"}, {31'h0, MemtoReg_WB}, {31'h0, m_mtr});
      chk({tag, ".Read_Data_WB"}, Read_Data_WB, m_rd);
      chk({tag, ".ALU_Result_WB"}, ALU_Result_WB, m_alu);
      chk({tag, ".Instruction_WB"}, Instruction_WB, m_ins);
      chk({tag, ".Write_Register_WB"}, {27'h0, Write_Register_WB}, {27'h0, m_wreg});
      chk({tag, ".Stall_Count"}, {16'h0, Stall_Count}, m_scnt[31:0]);
      chk({tag, ".Align_Fault"}, {31'h0, Align_Fault}, {31'h0, exp_align});
      chk({tag, ".Mem_Fault"}, {31'h0, Mem_Fault}, {31'h0, exp_mf});
   endtask

   task automatic model_reset();
      m_rw = 1'b0; m_mtr = 1'b0; m_rd = '0; m_alu = '0; m_ins = '0; m_wreg = '0; m_scnt = 0;
   endtask

   task automatic model_bubble(input logic stalled);
      m_rw = 1'b0; m_mtr = 1'b0; m_ins = '0;
      if (stalled && m_scnt < 65535) m_scnt++;
   endtask

   task automatic clear_inputs();
      RegWrite_MEM = 0; MemtoReg_MEM = 0; Branch_MEM = 0; MemRead_MEM = 0; MemWrite_MEM = 0;
      Zero_MEM = 0; Branch_Dest_MEM = '0; ALU_Result_MEM = '0; Write_Data_MEM = '0;
      Instruction_MEM = '0; Write_Register_MEM = '0; Dmem_Ack = 0; Dmem_Rdata = '0;
   endtask

   // One instruction through the stage. lat = request cycles without ack before
   // the ack cycle (only meaningful for an aligned access).
   task automatic run_instr(input string tag, input logic rd, input logic wr, input logic rw,
                            input logic mtr, input logic br, input logic zr,
                            input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] bd,
                            input logic [31:0] ins, input logic [31:0] rdata,
                            input logic [4:0] wreg, input int lat);
      logic access, aligned;
      access  = rd | wr;
      aligned = (alu[1:0] == 2'b00);
      @(negedge Clk);
      RegWrite_MEM = rw; MemtoReg_MEM = mtr; Branch_MEM = br; Zero_MEM = zr;
      MemRead_MEM = rd; MemWrite_MEM = wr; Branch_Dest_MEM = bd; Instruction_MEM = ins;
      Write_Register_MEM = wreg; ALU_Result_MEM = alu; Write_Data_MEM = wd;
      if (access && aligned) begin
         for (int k = 0; k <= lat; k++) begin
            if (k > 0) @(negedge Clk);
            // inputs in the middle of a wait must not disturb the latched request
            if (k > 0 && k < lat) begin
               ALU_Result_MEM = $urandom & 32'hFFFF_FFFC;
               Write_Data_MEM = $urandom;
            end else begin
               ALU_Result_MEM = alu;
               Write_Data_MEM = wd;
            end
            Dmem_Ack   = (k == lat);
            Dmem_Rdata = (k == lat) ? rdata : $urandom;
            #1;
            chk({tag, ".Dmem_Req"}, {31'h0, Dmem_Req}, 32'h1);
            chk({tag, ".Dmem_We"}, {31'h0, Dmem_We}, {31'h0, wr});
            chk({tag, ".Dmem_Addr"}, Dmem_Addr, alu);
            chk({tag, ".Dmem_Wdata"}, Dmem_Wdata, wd);
            chk({tag, ".Stall_MEM"}, {31'h0, Stall_MEM}, {31'h0, (k < lat)});
            chk({tag, ".PCSrc_MEM"}, {31'h0, PCSrc_MEM}, {31'h0, (br & zr & (k == lat))});
            chk({tag, ".Branch_Target"}, Branch_Target, bd);
            @(posedge Clk); #1;
            if (k < lat) begin
               model_bubble(1'b1);
            end else begin
               m_rw = rw; m_mtr = mtr; m_rd = wr ? 32'h0 : rdata;
               m_alu = alu; m_ins = ins; m_wreg = wreg;
            end
            chk_wb(tag, 1'b0, 1'b0);
         end
      end else begin
         Dmem_Ack   = $urandom_range(0, 1);   // stray ack with no request
         Dmem_Rdata = $urandom;
         #1;
         chk({tag, ".Dmem_Req"}, {31'h0, Dmem_Req}, 32'h0);
         chk({tag, ".Stall_MEM"}, {31'h0, Stall_MEM}, 32'h0);
         chk({tag, ".PCSrc_MEM"}, {31'h0, PCSrc_MEM}, {31'h0, (br & zr)});
         chk({tag, ".Branch_Target"}, Branch_Target, bd);
         @(posedge Clk); #1;
         if (access) begin
            model_bubble(1'b0);
         end else begin
            m_rw = rw; m_mtr = mtr; m_rd = '0; m_alu = alu; m_ins = ins; m_wreg = wreg;
         end
         chk_wb(tag, access, 1'b0);
      end
   endtask

   initial begin
      logic        rd, wr;
      logic [31:0] alu;
      int          kind;

      // ---------------- reset ----------------
      clear_inputs();
      Reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      chk("reset.Dmem_Req", {31'h0, Dmem_Req}, 32'h0);
      chk("reset.Stall_MEM", {31'h0, Stall_MEM}, 32'h0);
      chk_wb("reset", 1'b0, 1'b0);
      @(negedge Clk);
      Reset_n = 1'b1;

      // ---------------- directed ----------------
      run_instr("load0", 1, 0, 1, 1, 0, 0, 32'h100, 32'h0, 32'h0, 32'h8C08_0100, 32'hDEAD_BEEF, 5'd8, 0);
      chk("load0.Read_Data_WB", Read_Data_WB, 32'hDEAD_BEEF);
      run_instr("store3", 0, 1, 0, 0, 0, 0, 32'h40, 32'h1234_5678, 32'h0, 32'hAC09_0040, 32'h0, 5'd9, 2);
      chk("store3.Stall_Count", {16'h0, Stall_Count}, 32'd2);
      run_instr("misalign", 1, 0, 1, 1, 0, 0, 32'h102, 32'h0, 32'h0, 32'h8C0A_0102, 32'h0, 5'd10, 0);
      run_instr("br_taken", 0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 32'h400, 32'h1000_00FF, 32'h0, 5'd0, 0);
      run_instr("br_not", 0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h400, 32'h1000_00FF, 32'h0, 5'd0, 0);
      run_instr("br_stall", 1, 0, 1, 0, 1, 1, 32'h80, 32'h0, 32'h800, 32'h1234_0000, 32'h5555_AAAA, 5'd3, 3);
      run_instr("both_st", 1, 1, 0, 0, 0, 0, 32'h44, 32'hCAFE_F00D, 32'h0, 32'hAC0B_0044, 32'h7777_7777, 5'd11, 4);
      run_instr("alu_op", 0, 0, 1, 0, 0, 0, 32'h0000_1234, 32'h0, 32'h0, 32'h0128_4020, 32'h0, 5'd12, 0);

`ifdef MEM_TIMEOUT_EN
      // ---------------- timeout abort ----------------
      @(negedge Clk);
      clear_inputs();
      MemRead_MEM = 1; RegWrite_MEM = 1; ALU_Result_MEM = 32'h200;
      Instruction_MEM = 32'h8C0D_0200; Write_Register_MEM = 5'd13;
      for (int k = 0; k <= TO_CYC; k++) begin
         if (k > 0) @(negedge Clk);
         #1;
         chk("tmo.Dmem_Req", {31'h0, Dmem_Req}, 32'h1);
         chk("tmo.Stall_MEM", {31'h0, Stall_MEM}, 32'h1);
         @(posedge Clk); #1;
         model_bubble(1'b1);
         chk_wb("tmo", 1'b0, (k == TO_CYC));
      end
      @(negedge Clk);
      Dmem_Ack = 1; Dmem_Rdata = 32'hBAD0_BAD0;   // late ack, must be ignored
      #1;
      chk("tmo_after.Dmem_Req", {31'h0, Dmem_Req}, 32'h0);
      chk("tmo_after.Stall_MEM", {31'h0, Stall_MEM}, 32'h0);
      @(posedge Clk); #1;
      model_bubble(1'b0);
      chk_wb("tmo_after", 1'b0, 1'b0);
      run_instr("tmo_next", 0, 0, 1, 0, 0, 0, 32'h99, 32'h0, 32'h0, 32'h0000_0099, 32'h0, 5'd14, 0);
`endif

      // ---------------- reset in the middle of a wait ----------------
      @(negedge Clk);
      clear_inputs();
      MemWrite_MEM = 1; ALU_Result_MEM = 32'h80; Write_Data_MEM = 32'hA5A5_A5A5;
      #1;
      chk("rstwait.Dmem_Req0", {31'h0, Dmem_Req}, 32'h1);
      @(posedge Clk); #1;
      model_bubble(1'b1);
      chk_wb("rstwait", 1'b0, 1'b0);
      @(negedge Clk); #1;
      chk("rstwait.Dmem_Req1", {31'h0, Dmem_Req}, 32'h1);
      #1;
      Reset_n = 1'b0;
      #1;
      model_reset();
      chk("rstwait.Dmem_Req_low", {31'h0, Dmem_Req}, 32'h0);
      chk("rstwait.Stall_low", {31'h0, Stall_MEM}, 32'h0);
      chk_wb("rstwait.in_reset", 1'b0, 1'b0);
      @(negedge Clk);
      clear_inputs();
      Dmem_Ack = 1; Dmem_Rdata = 32'h1111_2222;   // stray ack from the aborted access
      @(negedge Clk);
      Reset_n = 1'b1;
      #1;
      chk("rstwait.stray_req", {31'h0, Dmem_Req}, 32'h0);
      @(posedge Clk); #1;
      chk_wb("rstwait.stray", 1'b0, 1'b0);

      // ---------------- randomized ----------------
      for (int n = 0; n < 150; n++) begin
         kind = $urandom_range(0, 4);
         rd   = (kind == 1) || (kind == 3) || (kind == 4 && $urandom_range(0, 1) == 1);
         wr   = (kind == 2) || (kind == 3) || (kind == 4 && !rd);
         alu  = $urandom;
         if (kind == 4) begin
            if (alu[1:0] == 2'b00) alu[0] = 1'b1;
         end else if (kind != 0) begin
            alu[1:0] = 2'b00;
         end
         run_instr($sformatf("rnd%0d", n), rd, wr, 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), alu, $urandom, $urandom, $urandom, $urandom,
                   5'($urandom), $urandom_range(0, TO_CYC));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
